// File: rtl/ram_refresh_timer.sv
// DRAM CAS-before-RAS refresh request timer: accrues refresh debt every REF_PERIOD clocks, retires it on RefAck edges.
// Optional power-up refresh burst enabled by defining REF_INIT_EN.
module ram_refresh_timer #(
    parameter int unsigned REF_PERIOD   = 250,
    parameter int unsigned URGENT_LEVEL = 2,
    parameter int unsigned MAX_OWED     = 7,
    parameter int unsigned INIT_REFS    = 8
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       RefAck,
    output logic       RefReq,
    output logic       RefUrgent,
    output logic [3:0] Owed,
    output logic       RefOverrun,
    output logic       InitDone
);

    localparam logic [11:0] LAST_PRE = 12'(REF_PERIOD - 1);
    localparam logic [3:0]  MAX_Q    = 4'(MAX_OWED);
    localparam logic [3:0]  URGENT_Q = 4'(URGENT_LEVEL);
    localparam logic [3:0]  INIT_Q   = 4'(INIT_REFS);
`ifdef REF_INIT_EN
    localparam bit          INIT_EN  = 1'b1;
`else
    localparam bit          INIT_EN  = 1'b0;
`endif
    localparam logic [3:0]  RESET_OWED = INIT_EN ? INIT_Q : 4'd0;

    typedef enum logic [1:0] {IDLE, PEND, URGENT, SAT} debtState_t;

    debtState_t  debtState;
    logic [11:0] prescale;
    logic        ackQ;
    logic        tick;
    logic        done;
    logic [3:0]  owedNext;
    logic        overrunSet;

    assign tick = (prescale == LAST_PRE);
    assign done = RefAck & ~ackQ;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            prescale <= '0;
            ackQ     <= 1'b0;
        end else begin
            prescale <= tick ? '0 : prescale + 12'd1;
            ackQ     <= RefAck;
        end
    end

    // A tick and an ack edge in the same cycle cancel, leaving debt untouched.
    always_comb begin
        owedNext   = Owed;
        overrunSet = 1'b0;
        case ({tick, done})
            2'b10: begin
                if (Owed < MAX_Q) owedNext = Owed + 4'd1;
                else              overrunSet = InitDone;
            end
            2'b01: begin
                if (Owed != '0) owedNext = Owed - 4'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            Owed       <= RESET_OWED;
            RefOverrun <= 1'b0;
        end else begin
            Owed <= owedNext;
            if (overrunSet) RefOverrun <= 1'b1;
        end
    end

`ifdef REF_INIT_EN
    logic [3:0] initCnt;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            initCnt  <= '0;
            InitDone <= 1'b0;
        end else if (initCnt >= INIT_Q) begin
            InitDone <= 1'b1;
        end else if (done) begin
            initCnt <= initCnt + 4'd1;
            if (initCnt + 4'd1 == INIT_Q) InitDone <= 1'b1;
        end
    end
`else
    assign InitDone = 1'b1;
`endif

    always_comb begin
        if (Owed >= MAX_Q)         debtState = SAT;
        else if (Owed >= URGENT_Q) debtState = URGENT;
        else if (Owed != '0)       debtState = PEND;
        else                       debtState = IDLE;
    end

    assign RefReq    = (debtState != IDLE);
    assign RefUrgent = (debtState == URGENT) | (debtState == SAT) | ~InitDone;

endmodule
